mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side responder for the datapath load/store interface.
- Accepts one load or store per transaction. The address comes from the datapath's memory-location output and the store word from its store-data output.
- Runs a req/ack handshake with external word memory.
- Returns load data with a one-cycle valid pulse that drives the datapath's load-select input, and holds a stall output high until the access resolves. A per-access timeout flags bus errors.

Parameters:
- ADDR_W, 32, width of word address
- DATA_W, 32, width of data word
- TIMEOUT, 255, BUSY cycles without ack before error abort; 0 disables timeout; max 65535

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_ld  in  1  load request from control, level, sampled in IDLE
- req_st  in  1  store request from control, level, sampled in IDLE
- mem_loca  in  ADDR_W  word address from datapath
- st_data  in  DATA_W  store word from datapath
- ld  out  1  one-cycle pulse: ld_data valid; datapath routes ld_data onto operand C
- ld_data  out  DATA_W  registered load result
- stall  out  1  datapath must hold pc_inc/writes low
- bus_err  out  1  one-cycle pulse on timeout abort
- mem_req  out  1  external request, registered
- mem_we  out  1  1=write, 0=read; valid while mem_req
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  external completion, one cycle per access
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- rst mid-access: mem_req falls on the next edge. No ld or bus_err pulse. A later stray ack is ignored.
- States: IDLE, BUSY, RESP.
- IDLE:
  - On req_ld|req_st at edge N, latch mem_loca, st_data and we = ~req_ld into mem_addr/mem_wdata/mem_we. Set mem_req=1 from N+1. Go to BUSY and clear the counter.
  - If both requests are high, the load wins (mem_we=0).
- BUSY:
  - mem_req held high and address/data stable.
  - Counter increments each cycle without mem_ack.
  - mem_ack at edge M:
    - mem_req=0 from M+1.
    - Read: ld_data<=mem_rdata, go to RESP; ld=1 during cycle M+1 only.
    - Write: go directly to IDLE; no ld pulse.
  - TIMEOUT!=0 and counter reaches TIMEOUT-1 with no ack: mem_req=0 and bus_err=1 for the next cycle. Go to IDLE; ld_data unchanged; no ld pulse.
  - Ack on the same edge as timeout: the ack wins.
- RESP: one cycle, then IDLE. New requests are not sampled in RESP.
- stall (combinational) = (IDLE & (req_ld|req_st)) | BUSY. Low in RESP, so the datapath commits ld_data that cycle.
- Load latency: request edge N, zero-wait ack at N+1 (first cycle mem_req is high), ld pulse at N+2.
- Back-to-back: the next request is sampled at the first IDLE edge (N+3 for loads, N+2 for stores).
- mem_ack seen in IDLE or RESP is ignored.
- ld_data holds its value until the next successful load.

Decomposition:
- Package rapids_mem_pkg:
  - state enum {IDLE, BUSY, RESP}
  - TIMEOUT counter width constant (16)
  - ADDR_W/DATA_W defaults shared with the datapath
- One natural sub-module: mem_timeout_counter (clear, enable, limit, expired); 16-bit; expired never asserts when limit=0.

Test Plan:
- Load, zero-wait: req_ld=1, mem_loca=0x10, ack next cycle with rdata=0xDEADBEEF -> mem_req high 1 cycle, mem_we=0, mem_addr=0x10; ld pulse 2 cycles after request; ld_data=0xDEADBEEF; stall high 2 cycles.
- Store, 3 wait states: req_st=1, mem_loca=0x4, st_data=0x12345678, ack on 4th mem_req cycle -> mem_we=1, mem_wdata=0x12345678 stable throughout; no ld; stall drops the cycle after ack.
- Timeout: TIMEOUT=8, req_ld, never ack -> mem_req high exactly 8 cycles; bus_err 1-cycle pulse; ld_data keeps its prior value; stray ack later ignored.
- Collision and back-to-back: req_ld=req_st=1 -> read issued. Then a held req_st -> second access issues at the first IDLE edge after RESP.
- Reset mid-BUSY: rst asserted on the 2nd wait cycle -> mem_req=0 next edge; no ld or bus_err; a subsequent ack has no effect.
- TIMEOUT=0 with ack after 1000 cycles -> no bus_err; load completes normally.

Source files
------------

// File: rtl/rapids_mem_pkg.sv
// Shared widths and FSM encoding for the datapath memory access unit.
package rapids_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TMO_W      = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for one memory access; expired flags the last allowed cycle.
module mem_timeout_counter
  import rapids_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  localparam logic [TMO_W-1:0] ONE = TMO_W'(1);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

  // A zero limit means "wait forever", so it must never match.
  assign expired = (limit != '0) && (count == (limit - ONE));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side responder: turns datapath load/store requests into a req/ack
// handshake with external word memory, with load return and timeout abort.
module mem_access_unit
  import rapids_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ld,
  input  logic              req_st,
  input  logic [ADDR_W-1:0] mem_loca,
  input  logic [DATA_W-1:0] st_data,
  output logic              ld,
  output logic [DATA_W-1:0] ld_data,
  output logic              stall,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT);

  state_t state;
  logic   expired;
  logic   busy;

  assign busy = (state == ST_BUSY);

  mem_timeout_counter u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .enable  (busy && !mem_ack),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ld        <= 1'b0;
      ld_data   <= '0;
      bus_err   <= 1'b0;
    end else begin
      ld      <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A simultaneous load and store resolves to the load.
          if (req_ld || req_st) begin
            state     <= ST_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= !req_ld;
            mem_addr  <= mem_loca;
            mem_wdata <= st_data;
          end
        end
        ST_BUSY: begin
          // An ack on the timeout edge still completes the access.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= ST_IDLE;
            end else begin
              ld_data <= mem_rdata;
              ld      <= 1'b1;
              state   <= ST_RESP;
            end
          end else if (expired) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Low during RESP so the datapath commits ld_data in that cycle.
  assign stall = ((state == ST_IDLE) && (req_ld || req_st)) || busy;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations and a no-timeout instance.
module tb_mem_access_unit;

  localparam int TO_A = 8;

  logic        clk;
  logic        rst;
  logic        req_ld, req_st;
  logic [31:0] mem_loca, st_data;
  logic        ld, stall, bus_err, mem_req, mem_we, mem_ack;
  logic [31:0] ld_data, mem_addr, mem_wdata, mem_rdata;

  logic        req_ld_b, mem_ack_b;
  logic [31:0] mem_rdata_b;
  logic        ld_b, stall_b, bus_err_b, mem_req_b, mem_we_b;
  logic [31:0] ld_data_b, mem_addr_b, mem_wdata_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Model: one open access with its age, or a response cycle, or idle.
  bit          m_open, m_resp;
  int          m_age;
  bit          exp_ld, exp_err, exp_req, exp_we;
  logic [31:0] exp_ld_data, exp_addr, exp_wdata;

  int req_cycles, err_pulses;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .req_ld(req_ld), .req_st(req_st),
    .mem_loca(mem_loca), .st_data(st_data), .ld(ld), .ld_data(ld_data),
    .stall(stall), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .req_ld(req_ld_b), .req_st(1'b0),
    .mem_loca(mem_loca), .st_data(st_data), .ld(ld_b), .ld_data(ld_data_b),
    .stall(stall_b), .bus_err(bus_err_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ack(mem_ack_b),
    .mem_rdata(mem_rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic s, input logic [31:0] a,
                               input logic [31:0] d, input logic ack,
                               input logic [31:0] rd);
    req_ld    = l;
    req_st    = s;
    mem_loca  = a;
    st_data   = d;
    mem_ack   = ack;
    mem_rdata = rd;
    #1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_open = 0; m_resp = 0; m_age = 0;
      exp_ld = 0; exp_err = 0; exp_req = 0; exp_we = 0;
      exp_ld_data = '0; exp_addr = '0; exp_wdata = '0;
    end else begin
      exp_ld  = 0;
      exp_err = 0;
      if (m_resp) begin
        m_resp = 0;
      end else if (m_open) begin
        if (mem_ack) begin
          m_open  = 0;
          exp_req = 0;
          if (!exp_we) begin
            exp_ld_data = mem_rdata;
            exp_ld      = 1;
            m_resp      = 1;
          end
        end else if (TO_A != 0 && m_age == TO_A - 1) begin
          m_open  = 0;
          exp_req = 0;
          exp_err = 1;
        end else begin
          m_age++;
        end
      end else if (req_ld || req_st) begin
        m_open    = 1;
        m_age     = 0;
        exp_req   = 1;
        exp_we    = !req_ld;
        exp_addr  = mem_loca;
        exp_wdata = st_data;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cmp_ld", ld, exp_ld);
      checkOutput("cmp_ld_data", ld_data, exp_ld_data);
      checkOutput("cmp_bus_err", bus_err, exp_err);
      checkOutput("cmp_mem_req", mem_req, exp_req);
      checkOutput("cmp_stall", stall, m_open || (!m_resp && (req_ld || req_st)));
      if (exp_req) begin
        checkOutput("cmp_mem_we", mem_we, exp_we);
        checkOutput("cmp_mem_addr", mem_addr, exp_addr);
        checkOutput("cmp_mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_ld_b = 0; mem_ack_b = 0; mem_rdata_b = '0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    step();
    cmp_en = 1;
    checkOutput("rst_ld", ld, 0);
    checkOutput("rst_ld_data", ld_data, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_bus_err", bus_err, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    $display("[TB] zero-wait load");
    applyStimulus(1, 0, 32'h10, 0, 0, 0);
    checkOutput("ld0_stall_idle", stall, 1);
    step();
    applyStimulus(0, 0, 32'h10, 0, 1, 32'hDEADBEEF);
    checkOutput("ld0_mem_req", mem_req, 1);
    checkOutput("ld0_mem_we", mem_we, 0);
    checkOutput("ld0_mem_addr", mem_addr, 32'h10);
    checkOutput("ld0_stall_busy", stall, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ld0_pulse", ld, 1);
    checkOutput("ld0_data", ld_data, 32'hDEADBEEF);
    checkOutput("ld0_model_data", exp_ld_data, 32'hDEADBEEF);
    checkOutput("ld0_req_low", mem_req, 0);
    checkOutput("ld0_stall_resp", stall, 0);
    step();
    checkOutput("ld0_pulse_end", ld, 0);

    $display("[TB] store with three wait states");
    applyStimulus(0, 1, 32'h4, 32'h12345678, 0, 0);
    step();
    for (int w = 0; w < 4; w++) begin
      applyStimulus(0, 0, 32'hFFFF_0000 + w, 32'h0, (w == 3), 0);
      checkOutput("st_mem_req", mem_req, 1);
      checkOutput("st_mem_we", mem_we, 1);
      checkOutput("st_mem_addr", mem_addr, 32'h4);
      checkOutput("st_mem_wdata", mem_wdata, 32'h12345678);
      checkOutput("st_no_ld", ld, 0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("st_req_low", mem_req, 0);
    checkOutput("st_stall_low", stall, 0);
    checkOutput("st_no_ld_after", ld, 0);
    step();
    checkOutput("st_no_ld_later", ld, 0);

    $display("[TB] timeout abort");
    applyStimulus(1, 0, 32'h40, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    req_cycles = 0;
    err_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) req_cycles++;
      if (bus_err) err_pulses++;
      checkOutput("to_no_ld", ld, 0);
      step();
    end
    checkOutput("to_req_cycles", req_cycles, 8);
    checkOutput("to_err_pulses", err_pulses, 1);
    checkOutput("to_ld_data_kept", ld_data, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 1, 32'h0BADF00D);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stray_no_ld", ld, 0);
    checkOutput("stray_ld_data", ld_data, 32'hDEADBEEF);
    checkOutput("stray_no_req", mem_req, 0);

    $display("[TB] collision and back-to-back");
    applyStimulus(1, 1, 32'h20, 32'h0000AA55, 0, 0);
    step();
    applyStimulus(0, 1, 32'h24, 32'h0000AA55, 1, 32'hCAFEF00D);
    checkOutput("col_mem_we", mem_we, 0);
    checkOutput("col_mem_addr", mem_addr, 32'h20);
    step();
    applyStimulus(0, 1, 32'h24, 32'h0000AA55, 0, 0);
    checkOutput("col_ld", ld, 1);
    checkOutput("col_ld_data", ld_data, 32'hCAFEF00D);
    checkOutput("col_resp_stall", stall, 0);
    step();
    checkOutput("b2b_idle_req", mem_req, 0);
    checkOutput("b2b_idle_stall", stall, 1);
    step();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("b2b_req", mem_req, 1);
    checkOutput("b2b_we", mem_we, 1);
    checkOutput("b2b_addr", mem_addr, 32'h24);
    checkOutput("b2b_wdata", mem_wdata, 32'h0000AA55);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();

    $display("[TB] reset mid-access");
    applyStimulus(1, 0, 32'h30, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();
    checkOutput("rstb_req", mem_req, 0);
    checkOutput("rstb_ld", ld, 0);
    checkOutput("rstb_err", bus_err, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 32'h77);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rstb_stray_ld", ld, 0);
    checkOutput("rstb_stray_req", mem_req, 0);
    checkOutput("rstb_stray_err", bus_err, 0);
    checkOutput("rstb_ld_data", ld_data, 0);
    step();

    $display("[TB] timeout disabled, ack after 1000 cycles");
    req_ld_b = 1;
    step();
    req_ld_b = 0;
    req_cycles = 0;
    err_pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      if (mem_req_b) req_cycles++;
      if (bus_err_b) err_pulses++;
      step();
    end
    mem_ack_b = 1;
    mem_rdata_b = 32'h55AA55AA;
    step();
    mem_ack_b = 0;
    checkOutput("nto_req_cycles", req_cycles, 1000);
    checkOutput("nto_err_pulses", err_pulses, 0);
    checkOutput("nto_ld", ld_b, 1);
    checkOutput("nto_ld_data", ld_data_b, 32'h55AA55AA);
    checkOutput("nto_bus_err", bus_err_b, 0);
    checkOutput("nto_req_low", mem_req_b, 0);
    step();

    $display("[TB] randomized traffic");
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 1500; i++) begin
        rst = ($urandom_range(99) == 0);
        applyStimulus(($urandom_range(3) == 0), ($urandom_range(3) == 0),
                      $urandom, $urandom,
                      ($urandom_range(99) < ((phase == 0) ? 35 : 4)), $urandom);
        step();
      end
    end
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
